lsu_ctrl: RTL and testbench

Load/store sequencer between the single-cycle core's decode/ALU outputs and a ready-handshaked data memory bus. It converts the decoded access flags into byte-enabled word requests and holds the core with a stall while the bus is busy. It returns aligned, sign- or zero-extended load data and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 25 ++
 rtl/lsu_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer and its decoder.
// Holds the FSM states, the access size encoding and the byte-enable base patterns.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    // Major opcodes the decoder uses to raise d_rd_e / d_wr_e.
    localparam logic [6:0] I_load = 7'b0000011;
    localparam logic [6:0] S_mem  = 7'b0100011;

    function automatic logic [3:0] be_for(input size_e sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = BE_B << off;
            SZ_H:    be = BE_H << {off[1], 1'b0};
            default: be = BE_W;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a bus word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_rdata[{off, 3'b000} +: 8];
        half_v = mem_rdata[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    data = uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SZ_H:    data = uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns decoded access flags into one byte-enabled bus request,
// stalls the core while the bus is busy, and returns extended load data or a timeout.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_rd_e,
    input  logic              d_wr_e,
    input  logic              lb,
    input  logic              lh,
    input  logic              lw,
    input  logic              lbu,
    input  logic              lhu,
    input  logic              sb,
    input  logic              sh,
    input  logic              sw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              ld_valid,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                ld_valid_q, ld_valid_d;
    logic                bus_err_q, bus_err_d;
    size_e               size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          off_q, off_d;
    logic                is_load_q, is_load_d;

    logic                access;
    logic                illegal;
    logic                mis_cond;
    logic                start;
    logic                timeout;
    logic [2:0]          st_cnt;
    logic [2:0]          ld_cnt;
    size_e               dec_size;
    logic                dec_uns;
    logic [31:0]         dec_wdata;
    logic [31:0]         align_data;

    // Decode: when both enables are set the store flags alone decide legality.
    always_comb begin
        access  = d_rd_e | d_wr_e;
        st_cnt  = {2'b00, sb} + {2'b00, sh} + {2'b00, sw};
        ld_cnt  = {2'b00, lb} + {2'b00, lh} + {2'b00, lw} + {2'b00, lbu} + {2'b00, lhu};
        dec_size = SZ_W;
        dec_uns  = 1'b0;
        if (d_wr_e) begin
            illegal = (st_cnt != 3'd1);
            if (sb)      dec_size = SZ_B;
            else if (sh) dec_size = SZ_H;
        end else begin
            illegal = (ld_cnt != 3'd1);
            dec_uns = lbu | lhu;
            if (lb | lbu)      dec_size = SZ_B;
            else if (lh | lhu) dec_size = SZ_H;
        end
        case (dec_size)
            SZ_B:    dec_wdata = {4{wdata[7:0]}};
            SZ_H:    dec_wdata = {2{wdata[15:0]}};
            default: dec_wdata = wdata;
        endcase
        mis_cond = access & (illegal
                           | ((dec_size == SZ_H) & addr[0])
                           | ((dec_size == SZ_W) & (addr[1:0] != 2'b00)));
        start    = (state_q == IDLE) & access & ~mis_cond;
        timeout  = (state_q == REQ) & ~mem_ready & (cnt_q == CNT_LAST);
    end

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .off       (off_q),
        .size      (size_q),
        .uns       (uns_q),
        .data      (align_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (mem_ready | timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall    = start | (state_q == REQ);
        misalign = (state_q == IDLE) & mis_cond;
    end

    always_comb begin
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ld_valid_d  = 1'b0;
        bus_err_d   = 1'b0;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        is_load_d   = is_load_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_wr_e;
                    mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = be_for(dec_size, addr[1:0]);
                    mem_wdata_d = dec_wdata;
                    size_d      = dec_size;
                    uns_d       = dec_uns;
                    off_d       = addr[1:0];
                    is_load_d   = ~d_wr_e;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    mem_req_d  = 1'b0;
                    ld_valid_d = is_load_q;
                    if (is_load_q) rdata_d = align_data;
                end else if (timeout) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ld_valid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            is_load_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ld_valid_q  <= ld_valid_d;
            bus_err_q   <= bus_err_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            is_load_q   <= is_load_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;
    assign ld_valid  = ld_valid_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Table-driven bench for lsu_ctrl with a DONE-cycle scoreboard and reset/timeout sequences.
module tb_lsu_ctrl;

    localparam int MW = 4;

    localparam logic [7:0] F_LB  = 8'h80;
    localparam logic [7:0] F_LH  = 8'h40;
    localparam logic [7:0] F_LW  = 8'h20;
    localparam logic [7:0] F_LBU = 8'h10;
    localparam logic [7:0] F_LHU = 8'h08;
    localparam logic [7:0] F_SB  = 8'h04;
    localparam logic [7:0] F_SH  = 8'h02;
    localparam logic [7:0] F_SW  = 8'h01;

    logic        clk;
    logic        rst_n;
    logic        d_rd_e, d_wr_e;
    logic        lb, lh, lw, lbu, lhu, sb, sh, sw;
    logic [31:0] addr, wdata;
    logic        stall, ld_valid, misalign, bus_err, mem_req, mem_we, mem_ready;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    lsu_ctrl #(.MAX_WAIT(MW), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_rd_e    (d_rd_e),
        .d_wr_e    (d_wr_e),
        .lb        (lb),
        .lh        (lh),
        .lw        (lw),
        .lbu       (lbu),
        .lhu       (lhu),
        .sb        (sb),
        .sh        (sh),
        .sw        (sw),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .ld_valid  (ld_valid),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  fl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus;
        int          dly;   // REQ cycle in which mem_ready rises, 0 = never
        logic        mis;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
        logic [31:0] rexp;
        logic        lv;
    } vec_t;

    typedef struct {
        logic        lv;
        logic        berr;
        logic [31:0] rdata;
        logic        chk_rd;
    } exp_t;

    vec_t vecs[16];
    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    logic mreq_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Negedge sample; a falling mem_req marks the DONE cycle, where the scoreboard pops.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (mreq_prev && !mem_req) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got DONE expected no access");
                end else begin
                    e = sb_q.pop_front();
                    chk("ld_valid", ld_valid, e.lv);
                    chk("bus_err", bus_err, e.berr);
                    if (e.chk_rd) chk("rdata", rdata, e.rdata);
                end
            end else if (ld_valid || bus_err) begin
                tests++;
                fails++;
                $display("FAIL done_flags: got ld_valid=%0b bus_err=%0b expected 0 outside DONE",
                         ld_valid, bus_err);
            end
            mreq_prev = mem_req;
        end else begin
            mreq_prev = 1'b0;
        end
    endtask

    task automatic drive(input vec_t v);
        d_rd_e = v.rd;
        d_wr_e = v.wr;
        {lb, lh, lw, lbu, lhu, sb, sh, sw} = v.fl;
        addr      = v.addr;
        wdata     = v.wdata;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic clear_inputs();
        d_rd_e = 1'b0;
        d_wr_e = 1'b0;
        {lb, lh, lw, lbu, lhu, sb, sh, sw} = 8'h00;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
    endtask

    task automatic run(input int i);
        vec_t v;
        exp_t e;
        int   reqc;
        bit   done;
        v = vecs[i];
        @(posedge clk);
        #1;
        drive(v);
        if (!v.mis) begin
            e.lv     = v.lv;
            e.berr   = (v.dly == 0);
            e.rdata  = v.rexp;
            e.chk_rd = v.lv | (v.dly == 0);
            sb_q.push_back(e);
        end
        sample();
        chk("misalign_c0", misalign, v.mis);
        chk("stall_c0", stall, !v.mis);
        chk("req_c0", mem_req, 0);
        if (v.mis) begin
            @(posedge clk);
            #1;
            sample();
            chk("req_mis", mem_req, 0);
            chk("stall_mis", stall, 0);
        end else begin
            reqc = 0;
            done = 1'b0;
            for (int k = 1; k <= 40 && !done; k++) begin
                @(posedge clk);
                #1;
                mem_ready = (v.dly != 0) && (k >= v.dly);
                mem_rdata = v.bus;
                sample();
                if (!mem_req) begin
                    done = 1'b1;
                end else begin
                    reqc++;
                    chk("stall_req", stall, 1);
                    chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                    chk("mem_be", mem_be, v.be);
                    chk("mem_we", mem_we, v.we);
                    if (v.we) chk("mem_wdata", mem_wdata, v.wd);
                    if (mem_ready) begin
                        @(posedge clk);
                        #1;
                        mem_ready = 1'b0;
                        sample();
                        done = 1'b1;
                    end
                end
            end
            if (!done) begin
                tests++;
                fails++;
                $display("FAIL req_budget: got no DONE expected DONE within 40 cycles");
            end
            chk("stall_done", stall, 0);
            chk("req_done", mem_req, 0);
            chk("req_cycles", reqc, (v.dly != 0) ? v.dly : MW);
        end
        $display("[TB] vec %0d addr=%h mis=%0b rdata=%h ld_valid=%0b bus_err=%0b",
                 i, v.addr, misalign, rdata, ld_valid, bus_err);
    endtask

    initial begin
        //          rd wr  flags        addr           wdata          bus            dly mis be     we wd             rexp           lv
        vecs[0]  = '{0, 1, F_SW,        32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         1,  0, 4'hF,  1, 32'hDEAD_BEEF, 32'h0,         0};
        vecs[1]  = '{1, 0, F_LB,        32'h0000_0203, 32'h0,         32'h80FF_1234, 1,  0, 4'h8,  0, 32'h0,         32'hFFFF_FF80, 1};
        vecs[2]  = '{1, 0, F_LBU,       32'h0000_0203, 32'h0,         32'h80FF_1234, 1,  0, 4'h8,  0, 32'h0,         32'h0000_0080, 1};
        vecs[3]  = '{0, 1, F_SH,        32'h0000_0102, 32'h0000_ABCD, 32'h0,         3,  0, 4'hC,  1, 32'hABCD_ABCD, 32'h0,         0};
        vecs[4]  = '{1, 0, F_LHU,       32'h0000_0102, 32'h0,         32'h9876_0000, 2,  0, 4'hC,  0, 32'h0,         32'h0000_9876, 1};
        vecs[5]  = '{1, 0, F_LH,        32'h0000_0002, 32'h0,         32'h8001_0000, 1,  0, 4'hC,  0, 32'h0,         32'hFFFF_8001, 1};
        vecs[6]  = '{1, 0, F_LW,        32'h0000_0102, 32'h0,         32'h0,         1,  1, 4'h0,  0, 32'h0,         32'h0,         0};
        vecs[7]  = '{1, 0, F_LB | F_LH, 32'h0000_0000, 32'h0,         32'h0,         1,  1, 4'h0,  0, 32'h0,         32'h0,         0};
        vecs[8]  = '{0, 1, F_SH,        32'h0000_0003, 32'h0,         32'h0,         1,  1, 4'h0,  0, 32'h0,         32'h0,         0};
        vecs[9]  = '{1, 0, 8'h00,       32'h0000_0000, 32'h0,         32'h0,         1,  1, 4'h0,  0, 32'h0,         32'h0,         0};
        vecs[10] = '{0, 1, F_SB,        32'h0000_0101, 32'h0000_00A5, 32'h0,         2,  0, 4'h2,  1, 32'hA5A5_A5A5, 32'h0,         0};
        vecs[11] = '{1, 1, F_SW | F_LW, 32'h0000_0008, 32'h1122_3344, 32'h0,         1,  0, 4'hF,  1, 32'h1122_3344, 32'h0,         0};
        vecs[12] = '{1, 0, F_LB,        32'h0000_0001, 32'h0,         32'h0000_7F00, 1,  0, 4'h2,  0, 32'h0,         32'h0000_007F, 1};
        vecs[13] = '{1, 0, F_LW,        32'h0000_0000, 32'h0,         32'h1234_5678, 2,  0, 4'hF,  0, 32'h0,         32'h1234_5678, 1};
        vecs[14] = '{1, 0, F_LW,        32'h0000_0010, 32'h0,         32'hFFFF_FFFF, 0,  0, 4'hF,  0, 32'h0,         32'h0,         0};
        vecs[15] = '{0, 1, F_SB | F_SW, 32'h0000_0000, 32'h0,         32'h0,         1,  1, 4'h0,  0, 32'h0,         32'h0,         0};

        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ld_valid", ld_valid, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run(i);
        run(15);

        // Reset while a load is outstanding: the request must drop without a clock edge.
        @(posedge clk);
        #1;
        drive(vecs[13]);
        addr = 32'h0000_0040;
        sample();
        chk("rstreq_stall_c0", stall, 1);
        @(posedge clk);
        #1;
        sample();
        chk("rstreq_req_c1", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstreq_req_async", mem_req, 0);
        chk("rstreq_rdata", rdata, 0);
        chk("rstreq_ld_valid", ld_valid, 0);
        sb_q.delete();
        mreq_prev = 1'b0;
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        run(13);
        run(14);
        run(1);
        run(4);

        @(posedge clk);
        #1;
        clear_inputs();
        sample();
        sample();
        chk("idle_req", mem_req, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
